spec_free_list: RTL and testbench

//  Speculative free list of physical registers: the receiving end of the architectural map

---
 rtl/spec_free_list_pkg.sv | 36 +++
 rtl/spec_free_list_push_compact.sv | 27 ++
 rtl/spec_free_list.sv | 115 +++++++++++
 tb/tb_spec_free_list.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/spec_free_list_pkg.sv
// Shared rename constants, free-list types and the circular pointer helper.
package spec_free_list_pkg;

    localparam int SIZE_PHYSICAL_TABLE = 96;
    localparam int SIZE_RMT            = 32;
    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_FL             = SIZE_PHYSICAL_TABLE - SIZE_RMT;

    // Release packet width shared with the architectural map table
    localparam int RELEASE_WIDTH = 4;
    // Registers handed to rename per allocation
    localparam int GROUP         = 4;

    localparam int FL_PTR_W = $clog2(SIZE_FL);
    localparam int FL_CNT_W = $clog2(SIZE_FL + 1);

    typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_reg_t;
    typedef logic [FL_PTR_W-1:0]          fl_ptr_t;
    typedef logic [FL_PTR_W:0]            ptr_sum_t;
    typedef logic [FL_CNT_W-1:0]          fl_cnt_t;
    typedef logic [FL_CNT_W:0]            cnt_sum_t;
    typedef logic [2:0]                   push_cnt_t;

    localparam fl_cnt_t FL_DEPTH = fl_cnt_t'(SIZE_FL);

    // Advance a ring pointer by 0..4; compare-and-subtract so SIZE_FL need not be a power of 2
    function automatic fl_ptr_t fl_ptr_add(input fl_ptr_t ptr, input push_cnt_t inc);
        ptr_sum_t sum;
        sum = {1'b0, ptr} + ptr_sum_t'(inc);
        if (sum >= ptr_sum_t'(SIZE_FL)) begin
            sum = sum - ptr_sum_t'(SIZE_FL);
        end
        return sum[FL_PTR_W-1:0];
    endfunction

endpackage

// File: rtl/spec_free_list_push_compact.sv
// Packs the valid release slots to the front, oldest slot first, and counts them.
module spec_free_list_push_compact
    import spec_free_list_pkg::*;
(
    input  logic [RELEASE_WIDTH-1:0] valid_i,
    input  phys_reg_t                data_i  [RELEASE_WIDTH],
    output phys_reg_t                data_o  [RELEASE_WIDTH],
    output push_cnt_t                count_o
);

    // Walk the slots in order; each valid one lands at the next free output position
    always_comb begin
        push_cnt_t cnt;
        cnt = '0;
        for (int k = 0; k < RELEASE_WIDTH; k++) begin
            data_o[k] = '0;
        end
        for (int k = 0; k < RELEASE_WIDTH; k++) begin
            if (valid_i[k]) begin
                data_o[cnt[1:0]] = data_i[k];
                cnt = cnt + 3'd1;
            end
        end
        count_o = cnt;
    end

endmodule

// File: rtl/spec_free_list.sv
// Speculative physical-register free list: 4-wide allocate, 4-wide release, rollback on recovery.
module spec_free_list
    import spec_free_list_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      releasedValid0_i,
    input  logic      releasedValid1_i,
    input  logic      releasedValid2_i,
    input  logic      releasedValid3_i,
    input  phys_reg_t releasedPhyMap0_i,
    input  phys_reg_t releasedPhyMap1_i,
    input  phys_reg_t releasedPhyMap2_i,
    input  phys_reg_t releasedPhyMap3_i,
    input  logic      reqFreeReg_i,
    input  logic      recoverFlag_i,
    output phys_reg_t freeReg0_o,
    output phys_reg_t freeReg1_o,
    output phys_reg_t freeReg2_o,
    output phys_reg_t freeReg3_o,
    output logic      freeListEmpty_o
);

    phys_reg_t entry_q [SIZE_FL];
    fl_ptr_t   head_q, head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_cnt_t   count_q, count_d;
    cnt_sum_t  count_sum;

    logic [RELEASE_WIDTH-1:0] rel_valid;
    phys_reg_t                rel_map   [RELEASE_WIDTH];
    phys_reg_t                push_data [RELEASE_WIDTH];
    push_cnt_t                push_cnt;
    phys_reg_t                free_reg  [GROUP];
    logic                     pop;

    assign rel_valid  = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
    assign rel_map[0] = releasedPhyMap0_i;
    assign rel_map[1] = releasedPhyMap1_i;
    assign rel_map[2] = releasedPhyMap2_i;
    assign rel_map[3] = releasedPhyMap3_i;

    spec_free_list_push_compact u_compact (
        .valid_i (rel_valid),
        .data_i  (rel_map),
        .data_o  (push_data),
        .count_o (push_cnt)
    );

    // Zero-latency read of the four entries at the head
    for (genvar gi = 0; gi < GROUP; gi++) begin : g_read
        assign free_reg[gi] = entry_q[fl_ptr_add(head_q, push_cnt_t'(gi))];
    end

    assign freeReg0_o      = free_reg[0];
    assign freeReg1_o      = free_reg[1];
    assign freeReg2_o      = free_reg[2];
    assign freeReg3_o      = free_reg[3];
    assign freeListEmpty_o = (count_q < fl_cnt_t'(GROUP));

    // Allocation only when a full group exists and no rollback is in progress
    assign pop = reqFreeReg_i & ~freeListEmpty_o & ~recoverFlag_i;

    // Next head/tail/count; recovery reclaims the whole ring because stale slots still hold in-flight registers
    always_comb begin
        count_sum = {1'b0, count_q} + cnt_sum_t'(push_cnt);
        if (pop) begin
            count_sum = count_sum - cnt_sum_t'(GROUP);
        end
        if (count_sum > cnt_sum_t'(FL_DEPTH)) begin
            count_d = FL_DEPTH;
        end else begin
            count_d = count_sum[FL_CNT_W-1:0];
        end
        tail_d = fl_ptr_add(tail_q, push_cnt);
        head_d = pop ? fl_ptr_add(head_q, push_cnt_t'(GROUP)) : head_q;
        if (recoverFlag_i) begin
            head_d  = tail_d;
            count_d = FL_DEPTH;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= FL_DEPTH;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Ring storage: compacted releases written at tail onward; reset holds the non-architectural registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SIZE_FL; i++) begin
                entry_q[i] <= phys_reg_t'(SIZE_RMT + i);
            end
        end else begin
            for (int k = 0; k < RELEASE_WIDTH; k++) begin
                if (push_cnt > push_cnt_t'(k)) begin
                    entry_q[fl_ptr_add(tail_q, push_cnt_t'(k))] <= push_data[k];
                end
            end
        end
    end

    // More releases than free slots means the AMT released a register twice
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (cnt_sum_t'(count_q) + cnt_sum_t'(push_cnt) <= cnt_sum_t'(FL_DEPTH)));

endmodule

// File: tb/tb_spec_free_list.sv
// Randomized scoreboard bench for spec_free_list against a queue-based free-list model.
module tb_spec_free_list;
    import spec_free_list_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      v0, v1, v2, v3;
    phys_reg_t m0, m1, m2, m3;
    logic      req, rec;
    phys_reg_t f0, f1, f2, f3;
    logic      empty;

    always #5 clk = ~clk;

    spec_free_list dut (
        .clk               (clk),
        .reset             (reset),
        .releasedValid0_i  (v0),
        .releasedValid1_i  (v1),
        .releasedValid2_i  (v2),
        .releasedValid3_i  (v3),
        .releasedPhyMap0_i (m0),
        .releasedPhyMap1_i (m1),
        .releasedPhyMap2_i (m2),
        .releasedPhyMap3_i (m3),
        .reqFreeReg_i      (req),
        .recoverFlag_i     (rec),
        .freeReg0_o        (f0),
        .freeReg1_o        (f1),
        .freeReg2_o        (f2),
        .freeReg3_o        (f3),
        .freeListEmpty_o   (empty)
    );

    typedef struct {
        int cyc;
        bit chk_regs;
        int r [4];
        bit empty;
        int cnt;
    } exp_t;

    exp_t sbq [$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Model: fl = registers currently free, oldest first; hist = the last SIZE_FL registers ever placed in the list
    int fl   [$];
    int hist [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    task automatic model_reset();
        fl.delete();
        hist.delete();
        for (int i = 0; i < SIZE_FL; i++) begin
            fl.push_back(SIZE_RMT + i);
            hist.push_back(SIZE_RMT + i);
        end
    endtask

    task automatic push_expect(input int tgt);
        exp_t e;
        e.cyc      = tgt;
        e.cnt      = fl.size();
        e.empty    = (fl.size() < 4);
        e.chk_regs = !e.empty;
        for (int k = 0; k < 4; k++) e.r[k] = e.chk_regs ? fl[k] : 0;
        sbq.push_back(e);
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1
    task automatic apply(input bit rq, input bit rc, input bit [3:0] v, input int m [4]);
        int pushes [$];
        req = rq; rec = rc;
        v0 = v[0]; v1 = v[1]; v2 = v[2]; v3 = v[3];
        m0 = 7'(m[0]); m1 = 7'(m[1]); m2 = 7'(m[2]); m3 = 7'(m[3]);
        for (int k = 0; k < 4; k++) if (v[k]) pushes.push_back(m[k]);
        if (rq && !rc && fl.size() >= 4) repeat (4) void'(fl.pop_front());
        foreach (pushes[k]) begin
            fl.push_back(pushes[k]);
            hist.push_back(pushes[k]);
            if (hist.size() > SIZE_FL) void'(hist.pop_front());
        end
        if (rc) fl = hist;
        push_expect(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = 0; rec = 0; v0 = 0; v1 = 0; v2 = 0; v3 = 0;
        m0 = '0; m1 = '0; m2 = '0; m3 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_expect(cyc);
    endtask

    // Monitor: compare every due expectation against the live outputs
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            $display("txn cyc=%0d count=%0d empty=%0d regs=%0d,%0d,%0d,%0d", cyc,
                     int'(dut.count_q), empty, f0, f1, f2, f3);
            check("empty", int'(empty), int'(e.empty));
            check("count", int'(dut.count_q), e.cnt);
            if (e.chk_regs) begin
                check("freeReg0", int'(f0), e.r[0]);
                check("freeReg1", int'(f1), e.r[1]);
                check("freeReg2", int'(f2), e.r[2]);
                check("freeReg3", int'(f3), e.r[3]);
            end
        end
    end

    int z4  [4] = '{0, 0, 0, 0};
    int mr  [4];

    initial begin
        idle_inputs();
        reset = 1'b1;
        #12;
        // Reset state and empty-boundary: 16 groups drain it, the 17th request is ignored
        do_reset();
        repeat (17) apply(1, 0, 4'b0000, z4);
        apply(0, 1, 4'b0000, z4);

        // Compacted release with a hole in slot 1
        do_reset();
        apply(1, 0, 4'b0000, z4);
        apply(0, 0, 4'b1101, '{5, 99, 9, 11});
        check("entry0", int'(dut.entry_q[0]), 5);
        check("entry1", int'(dut.entry_q[1]), 9);
        check("entry2", int'(dut.entry_q[2]), 11);
        check("tail", int'(dut.tail_q), 3);

        // Drain to four, then pop and push in the same cycle
        do_reset();
        repeat (15) apply(1, 0, 4'b0000, z4);
        apply(1, 0, 4'b1111, '{40, 41, 42, 43});
        apply(0, 0, 4'b0000, z4);

        // Recovery reclaims the flushed registers; requests during recovery ignored
        do_reset();
        repeat (2) apply(1, 0, 4'b0000, z4);
        apply(0, 0, 4'b0001, '{7, 0, 0, 0});
        repeat (8) apply(1, 1, 4'b0000, z4);
        check("head_after_recover", int'(dut.head_q), 1);
        check("tail_after_recover", int'(dut.tail_q), 1);

        // Asynchronous reset in the middle of a push+pop cycle
        repeat (2) apply(1, 0, 4'b0000, z4);
        @(negedge clk);
        #1;
        req = 1; v0 = 1; v1 = 1; v2 = 1; v3 = 1;
        m0 = 7'd1; m1 = 7'd2; m2 = 7'd3; m3 = 7'd4;
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_f0", int'(f0), 32);
        check("async_rst_f1", int'(f1), 33);
        check("async_rst_f2", int'(f2), 34);
        check("async_rst_f3", int'(f3), 35);
        check("async_rst_empty", int'(empty), 0);
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_expect(cyc);

        // Random traffic; releases trimmed so the list never overflows
        for (int n = 0; n < 400; n++) begin
            bit        rq, rc;
            bit [3:0]  v;
            int        room, used;
            rq   = ($urandom_range(0, 3) != 0);
            rc   = ($urandom_range(0, 15) == 0);
            v    = 4'($urandom);
            room = SIZE_FL - fl.size();
            used = 0;
            for (int k = 0; k < 4; k++) begin
                mr[k] = $urandom_range(0, SIZE_PHYSICAL_TABLE - 1);
                if (v[k]) begin
                    if (used < room) used++;
                    else v[k] = 1'b0;
                end
            end
            apply(rq, rc, v, mr);
        end
        idle_inputs();
        @(negedge clk);
        #1;
        if (sbq.size() != 0) check("scoreboard_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
